wt_dcache_rd_arb: RTL and testbench

// - Arbiter/scheduler for the shared read port of the write-through dcache tag/data arrays.
// - Requesters: LD unit and PTW (high prio), and the write buffer (low prio).
// - Grants at most one read per cycle; blocked while the miss unit or write buffer owns the arrays.
// - Forwards the winner's tag/idx/off to the arrays and tags the 1-cycle-later response with the winning port.
// - Starvation guard promotes a waiting low-prio port after StarveLimit cycles.

---
 rtl/wt_dcache_rd_arb_if.sv | 37 +++
 rtl/wt_dcache_rd_arb.sv | 176 +++++++++++++++++
 tb/tb_wt_dcache_rd_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_dcache_rd_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : wt_dcache_rd_arb_if
// Description : Requester-side bus of the dcache read-port arbiter. Carries
//               per-port request, priority, tag_only flag and the flattened
//               tag/idx/off payloads, plus the one-hot grant back to the ports.
// Ports       : rd_req, rd_prio, rd_tag_only (NumPorts), rd_tag / rd_idx /
//               rd_off (NumPorts * field width, port p at slice p),
//               rd_ack (NumPorts, driven by the arbiter).
// Modports    : master = requester side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wt_dcache_rd_arb_if #(
    parameter int NumPorts            = 3,
    parameter int DCACHE_TAG_WIDTH    = 20,
    parameter int DCACHE_CL_IDX_WIDTH = 8,
    parameter int DCACHE_OFFSET_WIDTH = 4
) ();
    logic [NumPorts-1:0]                     rd_req;
    logic [NumPorts-1:0]                     rd_prio;
    logic [NumPorts-1:0]                     rd_tag_only;
    logic [NumPorts*DCACHE_TAG_WIDTH-1:0]    rd_tag;
    logic [NumPorts*DCACHE_CL_IDX_WIDTH-1:0] rd_idx;
    logic [NumPorts*DCACHE_OFFSET_WIDTH-1:0] rd_off;
    logic [NumPorts-1:0]                     rd_ack;

    modport master (
        output rd_req, rd_prio, rd_tag_only, rd_tag, rd_idx, rd_off,
        input  rd_ack
    );

    modport slave (
        input  rd_req, rd_prio, rd_tag_only, rd_tag, rd_idx, rd_off,
        output rd_ack
    );
endinterface
`default_nettype wire

// File: rtl/wt_dcache_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : wt_dcache_rd_arb
// Description : Read-port arbiter for the write-through dcache tag/data
//               arrays. Grants at most one read per cycle (starving low-prio
//               port first, then high-prio round-robin, then low-prio
//               round-robin), forwards the winner's payload to the arrays and
//               tags the one-cycle-later response with the winning port.
// Ports       : clk_i, rst_i (sync, active high)
//               rd             requester bus (wt_dcache_rd_arb_if.slave)
//               wr_busy_i      arrays owned by refill/inval/write this cycle
//               mem_*_o        array read enable and muxed payload
//               rsp_vld_o/rsp_port_o  registered response valid / owner
//               starve_o       forced grant this cycle
//               perf_conflict_o / perf_wrstall_o  performance counters
// Options     : WT_DCACHE_RD_ARB_PERF_EN enables the performance counters;
//               otherwise they read as zero and no flops exist.
// Revision    : 1.0 - initial release
// ============================================================================
module wt_dcache_rd_arb #(
    parameter int NumPorts            = 3,
    parameter int StarveLimit         = 8,
    parameter int DCACHE_TAG_WIDTH    = 20,
    parameter int DCACHE_CL_IDX_WIDTH = 8,
    parameter int DCACHE_OFFSET_WIDTH = 4
) (
    input  wire logic                           clk_i,
    input  wire logic                           rst_i,
    wt_dcache_rd_arb_if.slave                   rd,
    input  wire logic                           wr_busy_i,
    output logic                                mem_req_o,
    output logic [DCACHE_TAG_WIDTH-1:0]         mem_tag_o,
    output logic [DCACHE_CL_IDX_WIDTH-1:0]      mem_idx_o,
    output logic [DCACHE_OFFSET_WIDTH-1:0]      mem_off_o,
    output logic                                mem_tag_only_o,
    output logic                                rsp_vld_o,
    output logic [$clog2(NumPorts)-1:0]         rsp_port_o,
    output logic                                starve_o,
    output logic [31:0]                         perf_conflict_o,
    output logic [31:0]                         perf_wrstall_o
);
    localparam int PW = $clog2(NumPorts);
    // Keep at least one bit so StarveLimit=0 still elaborates.
    localparam int CW = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
    localparam logic [CW-1:0] C_LIMIT = CW'(StarveLimit);

    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       cnt_q [NumPorts];
    logic [CW-1:0]       cnt_d [NumPorts];
    logic                rsp_vld_q, rsp_vld_d;
    logic [PW-1:0]       rsp_port_q, rsp_port_d;

    logic [NumPorts-1:0] w_hi_cand, w_lo_cand, w_starve_cand, w_sel_cand;
    logic                w_grant;
    logic [PW-1:0]       w_win, w_mux_sel;

    // First candidate found scanning ptr, ptr+1, ... with wrap at NumPorts.
    function automatic logic [PW-1:0] rr_pick(input logic [NumPorts-1:0] cand,
                                              input logic [PW-1:0]       ptr);
        logic [PW-1:0] res;
        logic          found;
        int            idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NumPorts) idx = idx - NumPorts;
            for (int j = 0; j < NumPorts; j++) begin
                if (!found && (j == idx) && cand[j]) begin
                    res   = PW'(j);
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        w_hi_cand     = '0;
        w_lo_cand     = '0;
        w_starve_cand = '0;
        for (int p = 0; p < NumPorts; p++) begin
            w_hi_cand[p]     = rd.rd_req[p] &  rd.rd_prio[p];
            w_lo_cand[p]     = rd.rd_req[p] & ~rd.rd_prio[p];
            w_starve_cand[p] = (StarveLimit > 0) && w_lo_cand[p] && (cnt_q[p] == C_LIMIT);
        end

        if (|w_starve_cand)  w_sel_cand = w_starve_cand;
        else if (|w_hi_cand) w_sel_cand = w_hi_cand;
        else                 w_sel_cand = w_lo_cand;

        w_grant   = (|w_sel_cand) && !wr_busy_i && !rst_i;
        w_win     = rr_pick(w_sel_cand, rr_ptr_q);
        w_mux_sel = w_grant ? w_win : '0;

        rd.rd_ack = '0;
        if (w_grant) rd.rd_ack[w_win] = 1'b1;
        mem_req_o = w_grant;
        starve_o  = w_grant && (|w_starve_cand);

        // Payload of the winner; port 0 when idle (value is don't care).
        mem_tag_o      = rd.rd_tag[DCACHE_TAG_WIDTH-1:0];
        mem_idx_o      = rd.rd_idx[DCACHE_CL_IDX_WIDTH-1:0];
        mem_off_o      = rd.rd_off[DCACHE_OFFSET_WIDTH-1:0];
        mem_tag_only_o = rd.rd_tag_only[0];
        for (int p = 1; p < NumPorts; p++) begin
            if (w_mux_sel == PW'(p)) begin
                mem_tag_o      = rd.rd_tag[p*DCACHE_TAG_WIDTH +: DCACHE_TAG_WIDTH];
                mem_idx_o      = rd.rd_idx[p*DCACHE_CL_IDX_WIDTH +: DCACHE_CL_IDX_WIDTH];
                mem_off_o      = rd.rd_off[p*DCACHE_OFFSET_WIDTH +: DCACHE_OFFSET_WIDTH];
                mem_tag_only_o = rd.rd_tag_only[p];
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (w_grant) rr_ptr_d = (w_win == PW'(NumPorts - 1)) ? '0 : w_win + PW'(1);

        // Counters measure consecutive unserved cycles of a low-prio request.
        for (int p = 0; p < NumPorts; p++) begin
            if (!rd.rd_req[p] || rd.rd_ack[p] || rd.rd_prio[p]) cnt_d[p] = '0;
            else if (cnt_q[p] != C_LIMIT)                        cnt_d[p] = cnt_q[p] + CW'(1);
            else                                                 cnt_d[p] = cnt_q[p];
        end

        rsp_vld_d  = w_grant;
        rsp_port_d = w_mux_sel;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= '0;
            for (int p = 0; p < NumPorts; p++) cnt_q[p] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
            for (int p = 0; p < NumPorts; p++) cnt_q[p] <= cnt_d[p];
        end
    end

    assign rsp_vld_o  = rsp_vld_q;
    assign rsp_port_o = rsp_port_q;

`ifdef WT_DCACHE_RD_ARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_wrstall_q,  perf_wrstall_d;

    always_comb begin
        perf_conflict_d = perf_conflict_q;
        perf_wrstall_d  = perf_wrstall_q;
        if (($countones(rd.rd_req) >= 2) && (perf_conflict_q != 32'hFFFF_FFFF))
            perf_conflict_d = perf_conflict_q + 32'd1;
        if (wr_busy_i && (|rd.rd_req) && (perf_wrstall_q != 32'hFFFF_FFFF))
            perf_wrstall_d = perf_wrstall_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_conflict_q <= '0;
            perf_wrstall_q  <= '0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_wrstall_q  <= perf_wrstall_d;
        end
    end

    assign perf_conflict_o = perf_conflict_q;
    assign perf_wrstall_o  = perf_wrstall_q;
`else
    assign perf_conflict_o = 32'h0;
    assign perf_wrstall_o  = 32'h0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_wt_dcache_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_wt_dcache_rd_arb
// Description : Self-checking bench for wt_dcache_rd_arb (3 ports, ports 0/1
//               high priority, StarveLimit=4). Directed scenarios followed by
//               random traffic, all checked against a cycle-level model of
//               the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wt_dcache_rd_arb;
    localparam int N  = 3;
    localparam int SL = 4;
    localparam int TW = 20;
    localparam int IW = 8;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic          mem_req, mem_tag_only, rsp_vld, starve;
    logic [TW-1:0] mem_tag;
    logic [IW-1:0] mem_idx;
    logic [OW-1:0] mem_off;
    logic [1:0]    rsp_port;
    logic [31:0]   perf_conflict, perf_wrstall;

    always #5 clk = ~clk;

    wt_dcache_rd_arb_if #(.NumPorts(N), .DCACHE_TAG_WIDTH(TW),
                          .DCACHE_CL_IDX_WIDTH(IW), .DCACHE_OFFSET_WIDTH(OW)) rd_if ();

    wt_dcache_rd_arb #(.NumPorts(N), .StarveLimit(SL), .DCACHE_TAG_WIDTH(TW),
                       .DCACHE_CL_IDX_WIDTH(IW), .DCACHE_OFFSET_WIDTH(OW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rd              (rd_if),
        .wr_busy_i       (busy),
        .mem_req_o       (mem_req),
        .mem_tag_o       (mem_tag),
        .mem_idx_o       (mem_idx),
        .mem_off_o       (mem_off),
        .mem_tag_only_o  (mem_tag_only),
        .rsp_vld_o       (rsp_vld),
        .rsp_port_o      (rsp_port),
        .starve_o        (starve),
        .perf_conflict_o (perf_conflict),
        .perf_wrstall_o  (perf_wrstall)
    );

    int tests = 0;
    int fails = 0;

    logic [N-1:0]  prio_v;
    logic [TW-1:0] tag_a [N];
    logic [IW-1:0] idx_a [N];
    logic [OW-1:0] off_a [N];
    logic          tonly_a [N];

    // Reference model state
    int     m_rr;
    int     m_wait [N];
    bit     m_vld;
    int     m_port;
    longint m_conf, m_stall;

    logic [N-1:0] last_ack;
    logic         last_starve;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int p = 0; p < N; p++) begin
            tag_a[p]   = TW'($urandom);
            idx_a[p]   = IW'($urandom);
            off_a[p]   = OW'($urandom);
            tonly_a[p] = 1'($urandom);
        end
    endtask

    // First port, scanning from m_rr with wrap, whose class bit is set.
    function automatic int scan(input bit cls [N]);
        int p;
        for (int k = 0; k < N; k++) begin
            p = (m_rr + k) % N;
            if (cls[p]) return p;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model,
    // check registered outputs after the edge.
    task automatic cyc(input logic [N-1:0] req, input logic b, input logic r);
        bit           st [N];
        bit           hi [N];
        bit           lo [N];
        int           win, sel;
        bit           strv, grant;
        logic [N-1:0] e_ack;

        rst  = r;
        busy = b;
        rd_if.rd_req  = req;
        rd_if.rd_prio = prio_v;
        for (int p = 0; p < N; p++) begin
            rd_if.rd_tag[p*TW +: TW]  = tag_a[p];
            rd_if.rd_idx[p*IW +: IW]  = idx_a[p];
            rd_if.rd_off[p*OW +: OW]  = off_a[p];
            rd_if.rd_tag_only[p]      = tonly_a[p];
        end
        #1;

        for (int p = 0; p < N; p++) begin
            st[p] = req[p] && !prio_v[p] && (m_wait[p] == SL);
            hi[p] = req[p] && prio_v[p];
            lo[p] = req[p] && !prio_v[p];
        end
        win  = -1;
        strv = 1'b0;
        if (!r && !b) begin
            win = scan(st);
            if (win >= 0) strv = 1'b1;
            else begin
                win = scan(hi);
                if (win < 0) win = scan(lo);
            end
        end
        grant = (win >= 0);
        sel   = grant ? win : 0;
        e_ack = '0;
        if (grant) e_ack[win] = 1'b1;

        chk("ack",      64'(rd_if.rd_ack), 64'(e_ack));
        chk("mem_req",  64'(mem_req),      64'(grant));
        chk("starve",   64'(starve),       64'(strv));
        chk("mem_tag",  64'(mem_tag),      64'(tag_a[sel]));
        chk("mem_idx",  64'(mem_idx),      64'(idx_a[sel]));
        chk("mem_off",  64'(mem_off),      64'(off_a[sel]));
        chk("mem_tonly",64'(mem_tag_only), 64'(tonly_a[sel]));
        last_ack    = rd_if.rd_ack;
        last_starve = starve;

        for (int p = 0; p < N; p++) begin
            if (r || !req[p] || prio_v[p] || (grant && win == p)) m_wait[p] = 0;
            else if (m_wait[p] < SL)                              m_wait[p]++;
        end
        if (r) m_rr = 0;
        else if (grant) m_rr = (win + 1) % N;
        m_vld  = grant;
        m_port = sel;
        if (r) begin
            m_conf  = 0;
            m_stall = 0;
        end else begin
            if ($countones(req) >= 2 && m_conf < 64'hFFFF_FFFF) m_conf++;
            if (b && req != 0 && m_stall < 64'hFFFF_FFFF)      m_stall++;
        end

        @(posedge clk);
        #1;
        chk("rsp_vld", 64'(rsp_vld), 64'(m_vld));
        if (m_vld) chk("rsp_port", 64'(rsp_port), 64'(m_port));
`ifdef WT_DCACHE_RD_ARB_PERF_EN
        chk("perf_conflict", 64'(perf_conflict), 64'(m_conf));
        chk("perf_wrstall",  64'(perf_wrstall),  64'(m_stall));
`else
        chk("perf_conflict", 64'(perf_conflict), 64'd0);
        chk("perf_wrstall",  64'(perf_wrstall),  64'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] rq;
        prio_v = 3'b011;
        rst = 1'b1;
        busy = 1'b0;
        rd_if.rd_req = '0;
        rd_if.rd_prio = prio_v;
        rd_if.rd_tag_only = '0;
        rd_if.rd_tag = '0;
        rd_if.rd_idx = '0;
        rd_if.rd_off = '0;
        m_rr = 0; m_vld = 0; m_port = 0; m_conf = 0; m_stall = 0;
        for (int p = 0; p < N; p++) m_wait[p] = 0;
        rand_payload();
        @(negedge clk);

        // Reset gating with all ports requesting
        cyc(3'b111, 1'b0, 1'b1);
        cyc(3'b111, 1'b0, 1'b1);
        chk("rst_ack", 64'(last_ack), 64'd0);

        // Fairness between the two high-prio ports
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            cyc(3'b011, 1'b0, 1'b0);
            chk("fair_ack", 64'(last_ack), (i % 2 == 0) ? 64'b001 : 64'b010);
        end

        // Write stall: three blocked cycles, then the grant
        for (int i = 0; i < 3; i++) begin
            cyc(3'b001, 1'b1, 1'b0);
            chk("stall_ack", 64'(last_ack), 64'd0);
        end
        cyc(3'b001, 1'b0, 1'b0);
        chk("stall_rel_ack", 64'(last_ack), 64'b001);
`ifdef WT_DCACHE_RD_ARB_PERF_EN
        chk("stall_cnt", 64'(perf_wrstall), 64'd3);
`endif

        // Starvation: low-prio port 2 forced on the 5th cycle
        for (int i = 0; i < 4; i++) begin
            cyc(3'b111, 1'b0, 1'b0);
            chk("starve_pre", 64'(last_ack[2]), 64'd0);
        end
        cyc(3'b111, 1'b0, 1'b0);
        chk("starve_ack", 64'(last_ack), 64'b100);
        chk("starve_flag", 64'(last_starve), 64'd1);
        cyc(3'b111, 1'b0, 1'b0);
        chk("starve_after", 64'(last_ack), 64'b001);

        // Payload mux from port 1 alone
        rand_payload();
        idx_a[1] = 8'h2A;
        off_a[1] = 4'h8;
        tonly_a[1] = 1'b1;
        cyc(3'b010, 1'b0, 1'b0);
        chk("pay_ack", 64'(last_ack), 64'b010);
        chk("pay_port", 64'(rsp_port), 64'd1);

        // Perf counter over 10 contention cycles
        cyc(3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(3'b011, 1'b0, 1'b0);
`ifdef WT_DCACHE_RD_ARB_PERF_EN
        chk("perf10", 64'(perf_conflict), 64'd10);
`else
        chk("perf10", 64'(perf_conflict), 64'd0);
`endif

        // Random traffic; port 2 biased towards requesting so it can starve
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            rq[0] = 1'($urandom);
            rq[1] = 1'($urandom);
            rq[2] = ($urandom_range(0, 4) != 0);
            cyc(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
